seven_segment_scan: RTL and testbench

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

---
 rtl/seven_segment_scan.sv | 147 ++++++++++++++
 tb/tb_seven_segment_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan.sv
// Multiplexed hex seven-segment scanner: double-buffered digits, tear-free update at frame boundary.
// Latency: outputs registered one cycle after index/shadow state; optional LEADING_ZERO_BLANK_EN macro blanks leading zeros.
module seven_segment_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    enable,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [7:0]              segment_q, segment_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tc;
    logic                    frame_bnd;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   blank;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h18;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic upper_zero;
            upper_zero = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                upper_zero = upper_zero & (shadow_val_q[4*i +: 4] == 4'h0);
                blank[i]   = upper_zero;
            end
        end
`endif
    end

    always_comb begin
        tc        = (presc_q == PRESC_MAX);
        frame_bnd = tc && (idx_q == IDX_MAX);

        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp : pend_dp_q;

        // A load landing on the boundary bypasses pending so it is not delayed a whole frame.
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (frame_bnd) begin
            shadow_val_d = pend_val_d;
            shadow_dp_d  = pend_dp_d;
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = shadow_val_q[4*i +: 4];
                cur_dp    = shadow_dp_q[i];
                cur_blank = blank[i];
            end
        end

        segment_d   = 8'hFF;
        digit_sel_d = '1;
        if (enable) begin
            segment_d   = {~cur_dp, cur_blank ? 7'h7F : glyph(cur_nib)};
            digit_sel_d = ~(NUM_DIGITS'(1) << idx_q);
        end
        frame_done_d = frame_bnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            segment_q    <= 8'hFF;
            digit_sel_q  <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            segment_q    <= segment_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment    = segment_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan (NUM_DIGITS=4, SCAN_DIV=4): directed and random steps against a cycle-count model.
module tb_seven_segment_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        enable;
    logic [7:0]  segment;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_segment_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .enable     (enable),
        .segment    (segment),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Model: n counts edges since reset release; each digit lasts 4 edges, a frame 16.
    int          n;
    logic [15:0] pend_v, shad_v;
    logic [3:0]  pend_dp, shad_dp;
    logic [7:0]  glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                    8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n       = 0;
        pend_v  = '0;
        shad_v  = '0;
        pend_dp = '0;
        shad_dp = '0;
    endtask

    task automatic step();
        logic [7:0] exp_seg;
        logic [3:0] exp_sel;
        logic       exp_fd;
        int         d;
        d       = (n / 4) % 4;
        exp_seg = 8'hFF;
        exp_sel = 4'hF;
        if (enable) begin
            exp_seg = glyph_tbl[shad_v[4*d +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (shad_v >> (4*d)) == 16'h0) exp_seg[6:0] = 7'h7F;
`endif
            if (shad_dp[d]) exp_seg[7] = 1'b0;
            exp_sel = ~(4'b0001 << d);
        end
        exp_fd = (n % 16 == 15);
        if (n % 16 == 15) begin
            shad_v  = load ? value : pend_v;
            shad_dp = load ? dp : pend_dp;
        end
        if (load) begin
            pend_v  = value;
            pend_dp = dp;
        end
        n++;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("segment", 32'(segment), 32'(exp_seg));
        chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (enable) chk("one_hot", $countones(~digit_sel), 1);
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    initial begin
        rst_n  = 1'b0;
        value  = '0;
        dp     = '0;
        load   = 1'b0;
        enable = 1'b1;
        model_reset();
        #12;
        chk("reset_segment", 32'(segment), 32'hFF);
        chk("reset_digit_sel", 32'(digit_sel), 32'hF);
        chk("reset_frame_done", 32'(frame_done), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        value = 16'h1234;
        load  = 1'b1;
        step();
        chk("first_edge_digit0", 32'(digit_sel), 32'hE);
        run(16);
        chk("h1234_digit0_seg", 32'(segment), 32'h99);
        chk("h1234_digit0_sel", 32'(digit_sel), 32'hE);
        run(4);
        chk("h1234_digit1_seg", 32'(segment), 32'hB0);
        run(12);

        // Mid-frame load must not show until the next boundary.
        run(5);
        value = 16'hABCD;
        load  = 1'b1;
        step();
        run(4);
        chk("old_digit2_kept", 32'(segment), 32'hA4);
        run(40);

        value = 16'h0000;
        dp    = 4'b0010;
        load  = 1'b1;
        step();
        run(40);

        // Blank for 10 cycles mid-frame; scanning continues underneath.
        run(3);
        enable = 1'b0;
        run(10);
        chk("blank_segment", 32'(segment), 32'hFF);
        chk("blank_digit_sel", 32'(digit_sel), 32'hF);
        enable = 1'b1;
        run(20);

        // Load exactly on a frame boundary edge.
        while (n % 16 != 15) step();
        value = 16'h00F0;
        dp    = 4'b1000;
        load  = 1'b1;
        step();
        run(20);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom());
                if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
                dp   = 4'($urandom());
                load = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            step();
        end
        enable = 1'b1;

        // Asynchronous reset between edges drops pending data.
        value = 16'h5678;
        load  = 1'b1;
        step();
        rst_n = 1'b0;
        #2;
        chk("async_rst_segment", 32'(segment), 32'hFF);
        chk("async_rst_digit_sel", 32'(digit_sel), 32'hF);
        chk("async_rst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("post_rst_digit0", 32'(digit_sel), 32'hE);
        chk("post_rst_seg", 32'(segment), 32'hC0);
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
